// File: rtl/fpu_mul_rr_scheduler.sv
// Round-robin scheduler sharing one pipelined FP32 multiplier among NREQ requesters.
// Optional perf counters (perf_issued, perf_stall) are built when FPU_MUL_SCHED_PERF_EN is defined.
module fpu_mul_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 8,
    parameter int TAG_W = 2
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic [31:0]          rsp_data,
    output logic [31:0]          mul_a_tdata,
    output logic                 mul_a_tvalid,
    output logic [31:0]          mul_b_tdata,
    output logic                 mul_b_tvalid,
    input  logic                 mul_result_tvalid,
    input  logic [31:0]          mul_result_tdata,
    output logic                 err_orphan
`ifdef FPU_MUL_SCHED_PERF_EN
    ,
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_stall
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } rsp_entry_t;

    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] gnt_idx;
    logic             gnt_found;
    logic [CW-1:0]    outstanding;
    logic             can_issue;
    logic             issue;
    logic             pop;

    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [CW-1:0]    tq_wr, tq_rd;
    logic             tq_empty;
    logic             ret_ok;

    rsp_entry_t       fifo [DEPTH];
    logic [CW-1:0]    f_wr, f_rd;
    logic             fifo_empty;
    rsp_entry_t       head;

    assign can_issue  = outstanding < CW'(DEPTH);
    assign tq_empty   = (tq_wr == tq_rd);
    assign fifo_empty = (f_wr == f_rd);
    assign ret_ok     = mul_result_tvalid & ~tq_empty;

    // First requester at or above rr_ptr, wrapping at NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = TAG_W'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    // Gated by aresetn so the accept lines read 0 while reset is held.
    always_comb begin
        req_ready = '0;
        if (aresetn && can_issue && gnt_found)
            req_ready[gnt_idx] = 1'b1;
    end

    assign issue     = |(req_valid & req_ready);
    assign head      = fifo[f_rd[AW-1:0]];
    assign rsp_valid = ~fifo_empty;
    assign rsp_tag   = rsp_valid ? head.tag  : '0;
    assign rsp_data  = rsp_valid ? head.data : '0;
    assign pop       = rsp_valid & rsp_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr       <= '0;
            mul_a_tdata  <= '0;
            mul_b_tdata  <= '0;
            mul_a_tvalid <= 1'b0;
            mul_b_tvalid <= 1'b0;
            tq_wr        <= '0;
            tq_rd        <= '0;
            f_wr         <= '0;
            f_rd         <= '0;
            outstanding  <= '0;
            err_orphan   <= 1'b0;
        end else begin
            mul_a_tvalid <= issue;
            mul_b_tvalid <= issue;
            if (issue) begin
                mul_a_tdata <= req_a[int'(gnt_idx)*32 +: 32];
                mul_b_tdata <= req_b[int'(gnt_idx)*32 +: 32];
                rr_ptr      <= (gnt_idx == TAG_W'(NREQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
                tq_wr       <= tq_wr + CW'(1);
            end
            if (ret_ok) begin
                tq_rd <= tq_rd + CW'(1);
                f_wr  <= f_wr + CW'(1);
            end
            if (mul_result_tvalid && tq_empty)
                err_orphan <= 1'b1;
            if (pop)
                f_rd <= f_rd + CW'(1);
            case ({issue, pop})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Storage arrays carry no reset; the pointers above define validity.
    always_ff @(posedge aclk) begin
        if (issue)
            tag_q[tq_wr[AW-1:0]] <= gnt_idx;
        if (ret_ok)
            fifo[f_wr[AW-1:0]] <= '{tag: tag_q[tq_rd[AW-1:0]], data: mul_result_tdata};
    end

`ifdef FPU_MUL_SCHED_PERF_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (issue)
                perf_issued <= perf_issued + 32'd1;
            if (|req_valid && !can_issue)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
